// File: rtl/dvi_pkg.sv
// Shared DVI constants: TMDS symbol width, channel map, pixel-to-bit clock ratio
// and the default clock-channel symbol.
package dvi_pkg;

  localparam int TMDS_W  = 10;
  localparam int NUM_CH  = 4;
  localparam int DIV     = 5;
  localparam int PHASE_W = 3;

  localparam logic [TMDS_W-1:0] CLK_PATTERN_DEF = 10'b0000011111;

  localparam int CH_B   = 0;
  localparam int CH_G   = 1;
  localparam int CH_R   = 2;
  localparam int CH_CLK = 3;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DIV - 1);

endpackage

// File: rtl/tmds_shift10.sv
// One channel of the DDR serializer: 10-bit word register that loads a symbol
// and then shifts out two bits per bit-clock cycle, LSB first.
module tmds_shift10
  import dvi_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_load,
  input  logic [TMDS_W-1:0] i_word,
  output logic              o_rise,
  output logic              o_fall
);

  logic [TMDS_W-1:0] sr_q;
  logic [TMDS_W-1:0] sr_d;

  always_comb begin
    sr_d = {2'b00, sr_q[TMDS_W-1:2]};
    if (i_load) begin
      sr_d = i_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Outputs come straight from the flops so the DDR cells see no logic skew.
  assign o_rise = sr_q[0];
  assign o_fall = sr_q[1];

endmodule

// File: rtl/tmds_serializer.sv
// TMDS 10:1 serializer in the 5x bit-clock domain. A mod-5 phase counter, aligned
// with the pixel-clock divider by the shared reset, times symbol capture and load.
module tmds_serializer
  import dvi_pkg::*;
#(
  parameter int                LOAD_PHASE  = 2,
  parameter logic [TMDS_W-1:0] CLK_PATTERN = CLK_PATTERN_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [TMDS_W-1:0] i_sym0,
  input  logic [TMDS_W-1:0] i_sym1,
  input  logic [TMDS_W-1:0] i_sym2,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic              o_load,
  output logic [PHASE_W-1:0] o_phase
);

  // Capture at phase 4 would collide with the load of the same hold registers.
  if (LOAD_PHASE < 0 || LOAD_PHASE > 3) begin : g_bad_load_phase
    $error("tmds_serializer: LOAD_PHASE must be in 0..3");
  end

  localparam logic [PHASE_W-1:0] CAP_PHASE = PHASE_W'(LOAD_PHASE);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               capture;
  logic               load;

  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    if (phase_q == LAST_PHASE) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign capture = (phase_q == CAP_PHASE);
  assign load    = (phase_q == LAST_PHASE);

  logic [2:0][TMDS_W-1:0] hold_q;
  logic [2:0][TMDS_W-1:0] hold_d;

  always_comb begin
    hold_d = hold_q;
    if (capture) begin
      hold_d = {i_sym2, i_sym1, i_sym0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  logic [NUM_CH-1:0][TMDS_W-1:0] words;

  always_comb begin
    words         = '0;
    words[CH_B]   = hold_q[CH_B];
    words[CH_G]   = hold_q[CH_G];
    words[CH_R]   = hold_q[CH_R];
    words[CH_CLK] = CLK_PATTERN;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tmds_shift10 u_shift (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_load (load),
      .i_word (words[k]),
      .o_rise (o_rise[k]),
      .o_fall (o_fall[k])
    );
  end

  assign o_load  = load;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed bench for tmds_serializer: reset state, per-phase channel mapping,
// capture window, mid-word reset and the capture-to-output latency sweep.
module tb_tmds_serializer;

  logic       clk;
  logic       rstn;
  logic [9:0] sym0, sym1, sym2;
  logic [3:0] rise, fall;
  logic       load;
  logic [2:0] phase;

  logic [9:0] sw_sym   [4];
  logic [3:0] sw_rise  [4];
  logic [3:0] sw_fall  [4];
  logic       sw_load  [4];
  logic [2:0] sw_phase [4];

  int n_cmp = 0;
  int n_err = 0;

  // Hand-derived per-phase bit tables, bit index = phase.
  logic [4:0] clk_r = 5'b00111;  // 1,1,1,0,0
  logic [4:0] clk_f = 5'b00011;  // 1,1,0,0,0
  logic [4:0] ch1_r = 5'b11001;  // 1,0,0,1,1
  logic [4:0] ch1_f = 5'b10001;  // 1,0,0,0,1

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  tmds_serializer dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_sym0  (sym0),
    .i_sym1  (sym1),
    .i_sym2  (sym2),
    .o_rise  (rise),
    .o_fall  (fall),
    .o_load  (load),
    .o_phase (phase)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    tmds_serializer #(.LOAD_PHASE(g)) u_sw (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_sym0  (sw_sym[g]),
      .i_sym1  (10'h000),
      .i_sym2  (10'h000),
      .o_rise  (sw_rise[g]),
      .o_fall  (sw_fall[g]),
      .o_load  (sw_load[g]),
      .o_phase (sw_phase[g])
    );
  end

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel period starting at a negedge in phase 0; optionally changes sym2
  // at phase chg_ph. blank=1 expects all-zero data outputs.
  task automatic run_period(input bit blank, input logic [9:0] ch2w,
                            input int chg_ph, input logic [9:0] chg_v);
    logic [3:0] er, ef;
    for (int p = 0; p < 5; p++) begin
      if (p == chg_ph) sym2 = chg_v;
      if (blank) begin
        er = 4'b0000;
        ef = 4'b0000;
      end else begin
        er = {clk_r[p], ch2w[0], ch1_r[p], 1'b0};
        ef = {clk_f[p], ch2w[0], ch1_f[p], 1'b1};
      end
      chk($sformatf("phase_p%0d", p), 10'(phase), 10'(p));
      chk($sformatf("load_p%0d", p), 10'(load), 10'(p == 4));
      chk($sformatf("rise_p%0d", p), 10'(rise), 10'(er));
      chk($sformatf("fall_p%0d", p), 10'(fall), 10'(ef));
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    int lat;
    rstn = 1'b0;
    sym0 = 10'h000;
    sym1 = 10'h000;
    sym2 = 10'h000;
    for (int g = 0; g < 4; g++) sw_sym[g] = 10'h000;

    repeat (3) @(negedge clk);
    chk("rst_rise", 10'(rise), 10'h0);
    chk("rst_fall", 10'(fall), 10'h0);
    chk("rst_phase", 10'(phase), 10'h0);
    chk("rst_load", 10'(load), 10'h0);

    sym0 = 10'h2AA;
    sym1 = 10'b1101000011;
    sym2 = 10'h000;
    rstn = 1'b1;

    // Period 1 blank; then capture-window schedule on channel 2.
    run_period(1'b1, 10'h000, 9, 10'h000);
    run_period(1'b0, 10'h000, 3, 10'h3FF);  // change after capture
    run_period(1'b0, 10'h000, 9, 10'h000);
    run_period(1'b0, 10'h3FF, 1, 10'h000);
    run_period(1'b0, 10'h000, 1, 10'h3FF);  // change before capture
    run_period(1'b0, 10'h3FF, 9, 10'h000);
    run_period(1'b0, 10'h3FF, 9, 10'h000);

    // Mid-word reset at phase 2.
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_phase", 10'(phase), 10'd2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rise", 10'(rise), 10'h0);
    chk("mid_rst_fall", 10'(fall), 10'h0);
    chk("mid_rst_phase", 10'(phase), 10'h0);
    chk("mid_rst_load", 10'(load), 10'h0);
    @(negedge clk);
    rstn = 1'b1;
    run_period(1'b1, 10'h000, 9, 10'h000);
    run_period(1'b0, 10'h3FF, 9, 10'h000);

    // Latency sweep: capture edge counts as cycle 1.
    for (int g = 0; g < 4; g++) begin
      cnt = 0;
      while (sw_phase[g] != 3'(g) && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk($sformatf("sweep_sync_lp%0d", g), 10'(sw_phase[g]), 10'(g));
      sw_sym[g] = 10'h001;
      @(posedge clk);
      #1;
      sw_sym[g] = 10'h000;
      lat = 1;
      while (sw_rise[g][0] !== 1'b1 && lat < 12) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("latency_lp%0d", g), 10'(lat), 10'(5 - g));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
